// File: rtl/operand_entry_fsm_pkg.sv
// operand_entry_pkg: shared types and defaults for the operand entry front end.
//   entry_state_t            : state codes, also driven onto the entry_state LEDs
//   OPERAND_WIDTH            : default operand width
//   DEBOUNCE_CYCLES_DEFAULT  : 10 ms at 50 MHz
package operand_entry_pkg;

  localparam int OPERAND_WIDTH           = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // 2'd3 is unused; the FSM forces it back to GET_A
  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    READY = 2'd2
  } entry_state_t;

endpackage

// File: rtl/operand_entry_fsm_button_debouncer.sv
// button_debouncer: 2-flop synchroniser, debouncer and press detector for one
// active-low push button.
//   clk, reset  : clock, synchronous active-high reset
//   btn_n       : raw active-low button, asynchronous
//   level       : debounced pressed level (1 = pressed)
//   press_pulse : one-cycle strobe on the debounced released->pressed edge
// Build option OPERAND_DEBOUNCE_EN: when undefined the debounce counter is
// dropped and the synchronised level feeds the edge detector directly
// (bring-up/simulation only; DEBOUNCE_CYCLES is then ignored).
module button_debouncer
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press_pulse
);

  // Synchroniser is deliberately not reset so a button held through reset
  // keeps reading as pressed.
  logic [1:0] sync_q;
  logic       btn;
  always_ff @(posedge clk) sync_q <= {sync_q[0], ~btn_n};
  assign btn = sync_q[1];

  // Pulses are only allowed once the button has been seen released after
  // reset, so a press held through reset never produces an event.
  logic armed;

`ifdef OPERAND_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      level       <= 1'b0;
      cnt         <= '0;
      armed       <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      armed       <= armed | ~btn;
      press_pulse <= 1'b0;
      if (btn != level) begin
        // this cycle is the DEBOUNCE_CYCLES-th consecutive disagreement
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level       <= btn;
          cnt         <= '0;
          press_pulse <= btn & armed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES > 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      level       <= 1'b0;
      armed       <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      armed       <= armed | ~btn;
      level       <= btn;
      press_pulse <= btn & ~level & armed;
    end
  end
`endif

endmodule

// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: sequential operand entry for the 4-bit subtractor.
// Operands are set on one switch bank and confirmed with the enter key:
// first minuend, then subtrahend; a third enter returns to GET_A keeping
// the last operands on display. Clear zeroes both operands from any state.
//   clk, reset     : clock, synchronous active-high reset
//   switches       : raw operand value, asynchronous
//   enter_btn_n    : raw enter key, active-low
//   clear_btn_n    : raw clear key, active-low
//   minuend        : latched minuend
//   subtrahend     : latched subtrahend
//   operands_valid : high while in READY
//   load_pulse     : one-cycle strobe on entry to READY
//   entry_state    : current state code for LEDs
// Build option OPERAND_DEBOUNCE_EN enables the button debouncers.
module operand_entry_fsm
  import operand_entry_pkg::*;
#(
  parameter int WIDTH           = OPERAND_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches,
  input  logic             enter_btn_n,
  input  logic             clear_btn_n,
  output logic [WIDTH-1:0] minuend,
  output logic [WIDTH-1:0] subtrahend,
  output logic             operands_valid,
  output logic             load_pulse,
  output logic [1:0]       entry_state
);

  // switch synchroniser; capture uses stage 1
  logic [1:0][WIDTH-1:0] sw_q;
  always_ff @(posedge clk) sw_q <= {sw_q[0], switches};

  logic enter_p, clear_p;
  logic enter_level_unused, clear_level_unused;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk         (clk),
    .reset       (reset),
    .btn_n       (enter_btn_n),
    .level       (enter_level_unused),
    .press_pulse (enter_p)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk         (clk),
    .reset       (reset),
    .btn_n       (clear_btn_n),
    .level       (clear_level_unused),
    .press_pulse (clear_p)
  );

  entry_state_t state;
  assign entry_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= GET_A;
      minuend        <= '0;
      subtrahend     <= '0;
      operands_valid <= 1'b0;
      load_pulse     <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      if (clear_p) begin
        // clear wins over a coincident enter
        state          <= GET_A;
        minuend        <= '0;
        subtrahend     <= '0;
        operands_valid <= 1'b0;
      end else begin
        case (state)
          GET_A: if (enter_p) begin
            minuend <= sw_q[1];
            state   <= GET_B;
          end
          GET_B: if (enter_p) begin
            subtrahend     <= sw_q[1];
            state          <= READY;
            operands_valid <= 1'b1;
            load_pulse     <= 1'b1;
          end
          READY: if (enter_p) begin
            state          <= GET_A;
            operands_valid <= 1'b0;
          end
          default: begin
            state          <= GET_A;
            operands_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Testbench for operand_entry_fsm with DEBOUNCE_CYCLES = 4. A reference model
// steps once per clock edge and queues every expected change of the output
// tuple together with the cycle it must appear in; a monitor pops the queue
// whenever the DUT outputs change.
module tb_operand_entry_fsm;

  localparam int W  = 4;
  localparam int DB = 4;
`ifdef OPERAND_DEBOUNCE_EN
  localparam int N_EFF = DB;
`else
  localparam int N_EFF = 1;   // no debouncer: level follows the sync directly
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] switches = '0;
  logic         enter_btn_n = 1'b1;
  logic         clear_btn_n = 1'b1;
  logic [W-1:0] minuend, subtrahend;
  logic         operands_valid, load_pulse;
  logic [1:0]   entry_state;

  operand_entry_fsm #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk            (clk),
    .reset          (reset),
    .switches       (switches),
    .enter_btn_n    (enter_btn_n),
    .clear_btn_n    (clear_btn_n),
    .minuend        (minuend),
    .subtrahend     (subtrahend),
    .operands_valid (operands_valid),
    .load_pulse     (load_pulse),
    .entry_state    (entry_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // expected tuple = {state, minuend, subtrahend, valid, load}
  typedef struct { int cyc; logic [11:0] val; } exp_t;
  exp_t exp_q[$];

  // ---------------- reference model ----------------
  int          m_edges = 0;
  bit          m_esyn[2];          // synced enter, index 1 = current
  bit          m_csyn[2];
  logic [W-1:0] m_sw[2];
  bit          m_edeb, m_cdeb, m_earm, m_carm, m_ep, m_cp;
  int          m_erun, m_crun;
  int          m_st;
  logic [W-1:0] m_mi, m_su;
  bit          m_ld;
  logic [11:0] m_prev = 12'h000;

  // debounced level flips after N_EFF consecutive disagreeing cycles;
  // a press is reported only once the key was seen released since reset
  task automatic deb_step(input bit syn, input bit rst, inout bit deb,
                          inout int run, inout bit armed, output bit pulse);
    pulse = 1'b0;
    if (rst) begin
      deb = 1'b0; run = 0; armed = 1'b0;
    end else begin
      if (syn != deb) begin
        run++;
        if (run >= N_EFF) begin
          deb   = syn;
          run   = 0;
          pulse = syn && armed;
        end
      end else begin
        run = 0;
      end
      if (!syn) armed = 1'b1;
    end
  endtask

  task automatic model_step();
    logic [11:0] now;
    if (reset) begin
      m_st = 0; m_mi = '0; m_su = '0; m_ld = 1'b0;
    end else begin
      m_ld = 1'b0;
      if (m_cp) begin
        m_st = 0; m_mi = '0; m_su = '0;
      end else if (m_ep) begin
        if (m_st == 0)      begin m_mi = m_sw[1]; m_st = 1; end
        else if (m_st == 1) begin m_su = m_sw[1]; m_st = 2; m_ld = 1'b1; end
        else                m_st = 0;
      end
    end
    deb_step(m_esyn[1], reset, m_edeb, m_erun, m_earm, m_ep);
    deb_step(m_csyn[1], reset, m_cdeb, m_crun, m_carm, m_cp);
    m_esyn[1] = m_esyn[0]; m_esyn[0] = !enter_btn_n;
    m_csyn[1] = m_csyn[0]; m_csyn[0] = !clear_btn_n;
    m_sw[1]   = m_sw[0];   m_sw[0]   = switches;
    m_edges++;
    now = {2'(m_st), m_mi, m_su, (m_st == 2), m_ld};
    if (now != m_prev) begin
      exp_q.push_back('{cyc: m_edges, val: now});
      m_prev = now;
    end
  endtask

  // ---------------- monitor ----------------
  bit          mon_en = 1'b0;
  logic [11:0] mon_prev = 12'h000;
  logic [11:0] mon_cur;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {entry_state, minuend, subtrahend, operands_valid, load_pulse};
      if (mon_cur != mon_prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change got=%h required=no change cycle=%0d", mon_cur, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_cur != mon_e.val || cyc != mon_e.cyc) begin
            fails++;
            $display("FAIL output_tuple got=%h@%0d required=%h@%0d",
                     mon_cur, cyc, mon_e.val, mon_e.cyc);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic press(input bit clr, input bit ent, input logic [W-1:0] sw,
                       input int hold, input int gap);
    switches = sw;
    if (clr) clear_btn_n = 1'b0;
    if (ent) enter_btn_n = 1'b0;
    repeat (hold) tick();
    clear_btn_n = 1'b1;
    enter_btn_n = 1'b1;
    repeat (gap) tick();
  endtask

  initial begin
    m_esyn = '{0, 0}; m_csyn = '{0, 0}; m_sw = '{'0, '0};
    m_edeb = 0; m_cdeb = 0; m_earm = 0; m_carm = 0; m_ep = 0; m_cp = 0;
    m_erun = 0; m_crun = 0; m_st = 0; m_mi = '0; m_su = '0; m_ld = 0;

    reset = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    tests++;
    if ({entry_state, minuend, subtrahend, operands_valid, load_pulse} != 12'h000) begin
      fails++;
      $display("FAIL reset_state got=%h required=000",
               {entry_state, minuend, subtrahend, operands_valid, load_pulse});
    end
    mon_en = 1'b1;
    repeat (3) tick();

    // two clean entries: 9 - 3 reaches READY
    press(0, 1, 4'h9, 8, 8);
    press(0, 1, 4'h3, 8, 8);
    // enter in READY: back to GET_A, operands kept
    press(0, 1, 4'hA, 8, 8);
    // bouncing enter, then held: one capture of 5
    switches = 4'h5;
    enter_btn_n = 1'b0; tick();
    enter_btn_n = 1'b1; tick();
    enter_btn_n = 1'b0; tick();
    enter_btn_n = 1'b1; tick();
    enter_btn_n = 1'b0; repeat (10) tick();
    enter_btn_n = 1'b1; repeat (8) tick();
    // GET_B: clear and enter together, clear wins
    press(1, 1, 4'hC, 8, 8);
    // enter held through reset produces nothing until released and re-pressed
    enter_btn_n = 1'b0; repeat (3) tick();
    reset = 1'b1; repeat (3) tick();
    reset = 1'b0; repeat (20) tick();
    enter_btn_n = 1'b1; repeat (8) tick();
    press(0, 1, 4'h7, 8, 8);

    // randomized presses, bounces, clears and occasional resets
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        press(1, 0, W'($urandom), $urandom_range(1, 10), $urandom_range(1, 10));
      end else if (r == 1) begin
        press(1, 1, W'($urandom), $urandom_range(1, 10), $urandom_range(1, 10));
      end else if (r == 2) begin
        reset = 1'b1; repeat ($urandom_range(1, 3)) tick();
        reset = 1'b0; repeat ($urandom_range(0, 4)) tick();
      end else if (r < 6) begin
        switches = W'($urandom);
        for (int k = 0; k < 12; k++) begin
          enter_btn_n = 1'($urandom_range(0, 1));
          if (k == 6) switches = W'($urandom);
          tick();
        end
        enter_btn_n = 1'b1; repeat ($urandom_range(1, 10)) tick();
      end else begin
        press(0, 1, W'($urandom), $urandom_range(1, 10), $urandom_range(1, 10));
      end
    end

    enter_btn_n = 1'b1; clear_btn_n = 1'b1;
    repeat (20) tick();
    mon_en = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_changes got=%0d pending required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
